// File: rtl/mac_pkg.sv
// Shared definitions for the multi-lane MAC engine: FSM encoding,
// saturation limits/clamp and the lane packing helper.
package mac_pkg;

  typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_OUT} state_e;

  // Clamp arithmetic is done at a fixed wide width so one function serves any ACC_W/OUT_W <= 64.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] data;
  } sat_t;

  function automatic logic signed [SAT_W-1:0] sat_max(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  function automatic sat_t sat_clamp(input logic signed [SAT_W-1:0] acc, input int out_w);
    sat_t r;
    r.sat  = 1'b0;
    r.data = acc;
    if (acc > sat_max(out_w)) begin
      r.sat  = 1'b1;
      r.data = sat_max(out_w);
    end else if (acc < sat_min(out_w)) begin
      r.sat  = 1'b1;
      r.data = sat_min(out_w);
    end
    return r;
  endfunction

  // LSB of lane i inside a packed operand vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mac_vec_acc_if.sv
// Operand stream in, saturated dot-product result out, both valid/ready.
interface mac_vec_acc_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int OUT_W = 2*WIDTH
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [LANES*WIDTH-1:0] w_vec;
  logic [LANES*WIDTH-1:0] x_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_sat;

  modport slave (
    input  in_valid, in_last, w_vec, x_vec, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_last, w_vec, x_vec, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_lane.sv
// One registered signed WIDTH x WIDTH multiplier lane.
module mac_lane
  import mac_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [WIDTH-1:0]   w_i,
  input  logic [WIDTH-1:0]   x_i,
  output logic [2*WIDTH-1:0] prod_o
);
  logic signed [2*WIDTH-1:0] prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prod_q <= '0;
    else if (en_i) prod_q <= $signed(w_i) * $signed(x_i);
  end

  assign prod_o = prod_q;
endmodule

// File: rtl/mac_vec_acc.sv
// Multi-lane signed MAC: lane multipliers -> adder tree -> accumulator,
// with an ACC/DRAIN/OUT FSM presenting a saturated result per vector.
module mac_vec_acc
  import mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 2*WIDTH + 8,
  parameter int OUT_W = 2*WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mac_vec_acc_if.slave  bus
);
  state_e state_q, state_d;

  logic [LANES-1:0][2*WIDTH-1:0] prod;
  logic [1:0]                    vld_pipe_q, last_pipe_q;
  logic signed [ACC_W-1:0]       lane_sum, acc_q, acc_d;
  logic                          first_q, first_d;
  logic [OUT_W-1:0]              out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;
  logic                          accept, out_hs, capture;
  sat_t                          sat_res;
  logic                          unused_sat_hi;

  assign bus.in_ready  = (state_q == ST_ACC) & ~rst;
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign out_hs = bus.out_valid & bus.out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (accept),
      .w_i    (bus.w_vec[lane_lsb(i, WIDTH) +: WIDTH]),
      .x_i    (bus.x_vec[lane_lsb(i, WIDTH) +: WIDTH]),
      .prod_o (prod[i])
    );
  end

  // [0]: products registered, [1]: beat folded into acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[0], accept};
      last_pipe_q <= {last_pipe_q[0] & vld_pipe_q[0], accept & bus.in_last};
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + ACC_W'($signed(prod[i]));
  end

  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    if (vld_pipe_q[0]) begin
      acc_d   = first_q ? lane_sum : acc_q + lane_sum;
      first_d = 1'b0;
    end
    if (out_hs) first_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_ACC:   if (accept && bus.in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (vld_pipe_q[1] && last_pipe_q[1]) begin
                  state_d = ST_OUT;
                  capture = 1'b1;
                end
      ST_OUT:   if (bus.out_ready) state_d = ST_ACC;
      default:  state_d = ST_ACC;
    endcase
  end

  assign sat_res       = sat_clamp(SAT_W'(acc_q), OUT_W);
  assign unused_sat_hi = ^sat_res.data[SAT_W-1:OUT_W];

  always_comb begin
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (capture) begin
      out_data_d = sat_res.data[OUT_W-1:0];
      out_sat_d  = sat_res.sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      first_q    <= 1'b1;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      first_q    <= first_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end
endmodule

// File: tb/tb_mac_vec_acc.sv
// Directed bench for mac_vec_acc (WIDTH=8, LANES=4, ACC_W=24, OUT_W=16).
module tb_mac_vec_acc;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_vec_acc_if #(.WIDTH(WIDTH), .LANES(LANES), .OUT_W(OUT_W)) ifc ();

  mac_vec_acc #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    logic [31:0] v;
    v[7:0]   = a[7:0];
    v[15:8]  = b[7:0];
    v[23:16] = c[7:0];
    v[31:24] = d[7:0];
    return v;
  endfunction

  // Present a beat and hold it until the edge that accepts it; returns 1ns after that edge.
  task automatic send(input logic [31:0] w, input logic [31:0] x, input logic last);
    ifc.w_vec    = w;
    ifc.x_vec    = x;
    ifc.in_last  = last;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        return;
      end
    end
    ifc.in_valid = 1'b0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic collect(input string tag, input int exp, input logic sat);
    int n;
    n = 0;
    while (!ifc.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, ifc.out_valid, 1);
    chk({tag, "_data"}, $signed(ifc.out_data), exp);
    chk({tag, "_sat"}, ifc.out_sat, sat);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_done"}, ifc.out_valid, 0);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_last   = 1'b1;
    ifc.w_vec     = pk(9, 9, 9, 9);
    ifc.x_vec     = pk(9, 9, 9, 9);
    ifc.out_ready = 1'b1;

    // Reset state, with an in_valid pulse that must be ignored
    #12;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_data", $signed(ifc.out_data), 0);
    chk("rst_out_sat", ifc.out_sat, 0);
    chk("rst_in_ready", ifc.in_ready, 0);
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready", ifc.in_ready, 1);
    chk("rst_rel_out_valid", ifc.out_valid, 0);
    @(posedge clk);
    #1;

    // Single beat, latency of two edges
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1);
    chk("lat_n0", ifc.out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_n1", ifc.out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_n2", ifc.out_valid, 1);
    collect("dot70", 70, 1'b0);

    // Two beats with a 3-cycle gap; acc holds -6 during the gap
    send(pk(-3, 0, 0, 0), pk(2, 0, 0, 0), 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("gap_acc", $signed(dut.acc_q), -6);
    end
    send(pk(5, 0, 0, 0), pk(-4, 0, 0, 0), 1'b1);
    collect("two_beat", -26, 1'b0);

    // Saturation at both ends
    send(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b1);
    collect("sat_pos", 32767, 1'b1);
    send(pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b1);
    collect("sat_neg", -32768, 1'b1);

    // Backpressure with ignored beats on the input
    ifc.out_ready = 1'b0;
    send(pk(1, 1, 1, 1), pk(3, 3, 3, 3), 1'b1);
    n = 0;
    while (!ifc.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    ifc.w_vec    = pk(100, 100, 100, 100);
    ifc.x_vec    = pk(100, 100, 100, 100);
    ifc.in_last  = 1'b1;
    ifc.in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", ifc.out_valid, 1);
      chk("bp_data", $signed(ifc.out_data), 12);
      chk("bp_sat", ifc.out_sat, 0);
      chk("bp_in_ready", ifc.in_ready, 0);
    end
    ifc.in_valid = 1'b0;
    collect("bp", 12, 1'b0);
    send(pk(2, 0, 0, 0), pk(3, 0, 0, 0), 1'b1);
    collect("after_bp", 6, 1'b0);

    // Reset mid-vector between clock edges
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", ifc.out_valid, 0);
    chk("mid_rst_out_data", $signed(ifc.out_data), 0);
    chk("mid_rst_out_sat", ifc.out_sat, 0);
    chk("mid_rst_in_ready", ifc.in_ready, 0);
    chk("mid_rst_acc", $signed(dut.acc_q), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(pk(1, 1, 1, 1), pk(2, 2, 2, 2), 1'b1);
    collect("post_rst", 8, 1'b0);

    // Back-to-back: B waits on in_valid during A's drain/output
    send(pk(1, 0, 0, 0), pk(10, 0, 0, 0), 1'b1);
    ifc.w_vec    = pk(-1, -1, -1, -1);
    ifc.x_vec    = pk(5, 5, 5, 5);
    ifc.in_last  = 1'b1;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("b2b_a_valid", ifc.out_valid, 1);
    chk("b2b_a_data", $signed(ifc.out_data), 10);
    @(posedge clk);
    #1;
    chk("b2b_hs_valid", ifc.out_valid, 0);
    chk("b2b_in_ready", ifc.in_ready, 1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    chk("b2b_b_accepted", ifc.in_ready, 0);
    collect("b2b_b", -20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
